// File: rtl/fetch_pkg.sv
// Shared constants and response entry layout for the instruction fetch unit.
package fetch_pkg;

    localparam int WORD_DEFAULT = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [WORD_DEFAULT-1:0] instr;
        logic [WORD_DEFAULT-1:0] pc;
        logic                    fault;
    } fetch_entry_t;

endpackage

// File: rtl/imem_fetch_unit_if.sv
// Request, memory and response signals of the fetch unit.
// The slave modport is the fetch unit; master is the surrounding pipeline/memory.
interface imem_fetch_unit_if #(
    parameter int WORD  = fetch_pkg::WORD_DEFAULT,
    parameter int DEPTH = 1024
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              req_valid_i;
    logic              req_ready_o;
    logic [WORD-1:0]   pc_i;
    logic              flush_i;
    logic              mem_en_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [WORD-1:0]   mem_rdata_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [WORD-1:0]   rsp_instr_o;
    logic [WORD-1:0]   rsp_pc_o;
    logic              rsp_fault_o;

    modport slave (
        input  req_valid_i, pc_i, flush_i, mem_rdata_i, rsp_ready_i,
        output req_ready_o, mem_en_o, mem_addr_o, rsp_valid_o,
               rsp_instr_o, rsp_pc_o, rsp_fault_o
    );

    modport master (
        output req_valid_i, pc_i, flush_i, mem_rdata_i, rsp_ready_i,
        input  req_ready_o, mem_en_o, mem_addr_o, rsp_valid_o,
               rsp_instr_o, rsp_pc_o, rsp_fault_o
    );

endinterface

// File: rtl/fetch_fifo2.sv
// Two-entry response buffer; pop is applied before push so a full buffer can swap an entry.
module fetch_fifo2 #(
    parameter type entry_t = fetch_pkg::fetch_entry_t
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       push,
    input  entry_t     push_data,
    input  logic       pop,
    output entry_t     head_data,
    output logic [1:0] count
);

    entry_t slots [2];
    logic   rd_ptr;
    logic   wr_ptr;
    logic   do_pop;
    logic   do_push;

    assign do_pop    = pop && (count != 2'd0);
    assign do_push   = push && ((count != 2'd2) || do_pop);
    assign head_data = slots[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slots[0] <= '0;
            slots[1] <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
        end else if (clear) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= push_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction fetch unit: one outstanding synchronous memory read plus a two-entry buffer.
// Define FETCH_FAULT_EN to turn misaligned/out-of-range fetches into NOP fault responses.
module imem_fetch_unit
    import fetch_pkg::*;
#(
    parameter int WORD  = WORD_DEFAULT,
    parameter int DEPTH = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    imem_fetch_unit_if.slave     bus
);

    localparam int ADDR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [WORD-1:0] instr;
        logic [WORD-1:0] pc;
        logic            fault;
    } word_entry_t;

    logic            req_ready;
    logic            accept;
    logic            fault_chk;
    logic            rsp_valid;
    logic            pop;
    logic            push;
    logic            fifo_empty;
    logic [1:0]      fifo_count;
    logic [1:0]      occupancy;
    logic            inflight;
    logic            inflight_fault;
    logic [WORD-1:0] inflight_pc;
    word_entry_t     landed;
    word_entry_t     fifo_head;
    word_entry_t     rsp_src;

`ifdef FETCH_FAULT_EN
    assign fault_chk = (bus.pc_i[1:0] != 2'b00) ||
                       ({2'b00, bus.pc_i[WORD-1:2]} >= WORD'(DEPTH));
`else
    assign fault_chk = 1'b0;
`endif

    assign occupancy = fifo_count + {1'b0, inflight};
    assign pop       = rsp_valid && bus.rsp_ready_i;
    // Flush frees every slot, so the fetch presented alongside it can always be taken.
    assign req_ready = !rst_i && (bus.flush_i || ((occupancy - {1'b0, pop}) < 2'd2));
    assign accept    = bus.req_valid_i && req_ready;

    assign bus.req_ready_o = req_ready;
    assign bus.mem_en_o    = accept && !fault_chk;
    assign bus.mem_addr_o  = bus.pc_i[ADDR_W+1:2];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inflight       <= 1'b0;
            inflight_pc    <= '0;
            inflight_fault <= 1'b0;
        end else begin
            inflight <= accept;
            if (accept) begin
                inflight_pc    <= bus.pc_i;
                inflight_fault <= fault_chk;
            end
        end
    end

    always_comb begin
        landed.instr = inflight_fault ? WORD'(NOP_INSTR) : bus.mem_rdata_i;
        landed.pc    = inflight_pc;
        landed.fault = inflight_fault;
    end

    assign fifo_empty = (fifo_count == 2'd0);
    assign rsp_valid  = !fifo_empty || inflight;
    // Read data only lives one cycle; park it unless the bypass path consumes it now.
    assign push       = inflight && !(fifo_empty && bus.rsp_ready_i);
    assign rsp_src    = fifo_empty ? landed : fifo_head;

    fetch_fifo2 #(.entry_t(word_entry_t)) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .clear     (bus.flush_i),
        .push      (push),
        .push_data (landed),
        .pop       (pop && !fifo_empty),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_instr_o = rsp_valid ? rsp_src.instr : '0;
    assign bus.rsp_pc_o    = rsp_valid ? rsp_src.pc : '0;

`ifdef FETCH_FAULT_EN
    assign bus.rsp_fault_o = rsp_valid && rsp_src.fault;
`else
    assign bus.rsp_fault_o = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{bus.pc_i[WORD-1:ADDR_W+2], bus.pc_i[1:0], rsp_src.fault};
`endif

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Scoreboard bench for imem_fetch_unit: accepted fetches queue expected responses,
// which are popped and compared as the unit hands them to decode.
module tb_imem_fetch_unit;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_fetch_unit_if #(.WORD(32), .DEPTH(DEPTH)) bus ();
    imem_fetch_unit #(.WORD(32), .DEPTH(DEPTH)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic              obs_accept, obs_fire, obs_valid, obs_ready, obs_mem_en;
    logic [ADDR_W-1:0] obs_addr;
    exp_t              obs_rsp;

    function automatic logic [31:0] mem_word(input int idx);
        return (idx == 0) ? 32'h0050_0093 : 32'h1000_0013 + 32'(idx) * 32'h0001_0100;
    endfunction

    function automatic exp_t model(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.fault = 1'b0;
        e.instr = mem_word(int'(pc[ADDR_W+1:2]));
`ifdef FETCH_FAULT_EN
        if (pc[1:0] != 2'b00 || (pc >> 2) >= 32'(DEPTH)) begin
            e.fault = 1'b1;
            e.instr = 32'h0000_0013;
        end
`endif
        return e;
    endfunction

    always @(posedge clk)
        bus.mem_rdata_i <= bus.mem_en_o ? mem_word(int'(bus.mem_addr_o)) : 32'($urandom());

    // One clock cycle: sample at the falling edge, then step to just after the rising edge.
    task automatic tick();
        @(negedge clk);
        obs_accept = bus.req_valid_i && bus.req_ready_o;
        obs_fire   = bus.rsp_valid_o && bus.rsp_ready_i;
        obs_valid  = bus.rsp_valid_o;
        obs_ready  = bus.req_ready_o;
        obs_mem_en = bus.mem_en_o;
        obs_addr   = bus.mem_addr_o;
        obs_rsp    = '{instr: bus.rsp_instr_o, pc: bus.rsp_pc_o, fault: bus.rsp_fault_o};
        if (bus.flush_i) exp_q.delete();
        if (obs_accept) exp_q.push_back(model(bus.pc_i));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid_i = 1'b1;
        bus.pc_i        = 32'h0;
        bus.flush_i     = 1'b0;
        bus.rsp_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({bus.rsp_valid_o, bus.rsp_instr_o, bus.rsp_pc_o, bus.rsp_fault_o, bus.mem_en_o} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b instr=%h pc=%h fault=%b mem_en=%b, expected all zero",
                     bus.rsp_valid_o, bus.rsp_instr_o, bus.rsp_pc_o, bus.rsp_fault_o, bus.mem_en_o);
        end
        rst = 1'b0;
        bus.req_valid_i = 1'b0;
        #1;
        n_tests++;
        if (bus.req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: req_ready=%b, expected 1", bus.req_ready_o);
        end
        @(posedge clk);
        #1;
        exp_q.delete();
    endtask

    task automatic test_single();
        bus.req_valid_i = 1'b1;
        bus.pc_i        = 32'h0;
        bus.rsp_ready_i = 1'b1;
        tick();
        n_tests++;
        if ({obs_accept, obs_mem_en, obs_addr, obs_valid} !== {1'b1, 1'b1, {ADDR_W{1'b0}}, 1'b0}) begin
            n_fail++;
            $display("FAIL single_issue: accept=%b mem_en=%b addr=%h rsp_valid=%b, expected 1 1 0 0",
                     obs_accept, obs_mem_en, obs_addr, obs_valid);
        end
        bus.req_valid_i = 1'b0;
        tick();
        n_tests++;
        if ({obs_valid, obs_rsp.instr, obs_rsp.pc} !== {1'b1, 32'h0050_0093, 32'h0}) begin
            n_fail++;
            $display("FAIL single_rsp: valid=%b instr=%h pc=%h, expected 1 00500093 00000000",
                     obs_valid, obs_rsp.instr, obs_rsp.pc);
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   ready_low = 0;
        bus.rsp_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.req_valid_i = (i < 4);
            bus.pc_i        = 32'(i * 4);
            tick();
            if (i < 4 && !obs_ready) ready_low++;
            if (i >= 1 && i <= 4) begin
                n_tests++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                if (!obs_fire || obs_rsp !== e || obs_rsp.pc !== 32'((i - 1) * 4)) begin
                    n_fail++;
                    $display("FAIL b2b_rsp%0d: fire=%b instr=%h pc=%h, expected fire=1 instr=%h pc=%h",
                             i, obs_fire, obs_rsp.instr, obs_rsp.pc, e.instr, e.pc);
                end
            end
        end
        n_tests++;
        if (ready_low != 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_ready: ready_low_cycles=%0d leftover=%0d, expected 0 0", ready_low, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        exp_t e, first;
        int   accepted = 0, unstable = 0, have_first = 0, fires = 0;
        logic [31:0] pc = 32'h100;
        bus.rsp_ready_i = 1'b0;
        bus.req_valid_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bus.pc_i = pc;
            tick();
            if (obs_accept) begin accepted++; pc += 4; end
            if (obs_valid) begin
                if (have_first == 0) begin first = obs_rsp; have_first = 1; end
                else if (obs_rsp !== first) unstable++;
            end
        end
        n_tests++;
        if (accepted != 2 || obs_ready !== 1'b0 || exp_q.size() != 2) begin
            n_fail++;
            $display("FAIL bp_full: accepted=%0d req_ready=%b queued=%0d, expected 2 0 2",
                     accepted, obs_ready, exp_q.size());
        end
        n_tests++;
        if (unstable != 0 || have_first == 0) begin
            n_fail++;
            $display("FAIL bp_stable: unstable_cycles=%0d seen_valid=%0d, expected 0 1", unstable, have_first);
        end
        bus.rsp_ready_i = 1'b1;
        for (int c = 0; c < 15 && (exp_q.size() > 0 || accepted < 5); c++) begin
            bus.req_valid_i = (accepted < 5);
            bus.pc_i        = pc;
            tick();
            if (obs_accept) begin accepted++; pc += 4; end
            if (obs_fire) begin
                fires++;
                n_tests++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                if (obs_rsp !== e) begin
                    n_fail++;
                    $display("FAIL bp_drain: got instr=%h pc=%h, expected instr=%h pc=%h",
                             obs_rsp.instr, obs_rsp.pc, e.instr, e.pc);
                end
            end
        end
        bus.req_valid_i = 1'b0;
        n_tests++;
        if (fires != 5 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_count: responses=%0d leftover=%0d, expected 5 0", fires, exp_q.size());
        end
    endtask

    task automatic test_flush();
        int n_resp = 0, stale = 0;
        logic [31:0] pc = 32'h200;
        bus.rsp_ready_i = 1'b0;
        bus.req_valid_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            bus.pc_i = pc;
            tick();
            if (obs_accept) pc += 4;
        end
        bus.flush_i = 1'b1;
        bus.pc_i    = 32'h40;
        tick();
        n_tests++;
        if ({obs_accept, obs_mem_en, obs_addr} !== {1'b1, 1'b1, ADDR_W'(16)}) begin
            n_fail++;
            $display("FAIL flush_accept: accept=%b mem_en=%b addr=%h, expected 1 1 010",
                     obs_accept, obs_mem_en, obs_addr);
        end
        bus.flush_i     = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (obs_valid) begin
                n_resp++;
                n_tests++;
                if (obs_rsp !== model(32'h40)) begin
                    n_fail++;
                    $display("FAIL flush_rsp: got instr=%h pc=%h, expected instr=%h pc=00000040",
                             obs_rsp.instr, obs_rsp.pc, mem_word(16));
                end
            end
        end
        n_tests++;
        if (n_resp != 1) begin
            n_fail++;
            $display("FAIL flush_count: responses=%0d, expected 1", n_resp);
        end
        exp_q.delete();
        bus.rsp_ready_i = 1'b0;
        bus.req_valid_i = 1'b1;
        bus.pc_i        = 32'h280;
        repeat (2) tick();
        bus.req_valid_i = 1'b0;
        bus.flush_i     = 1'b1;
        tick();
        bus.flush_i     = 1'b0;
        bus.rsp_ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (obs_valid) stale++;
        end
        n_tests++;
        if (stale != 0) begin
            n_fail++;
            $display("FAIL flush_empty: stale valid cycles=%0d, expected 0", stale);
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        exp_t e;
        int   errs = 0, fires = 0;
        for (int c = 0; c < 300; c++) begin
            bus.req_valid_i = ($urandom_range(0, 3) != 0);
            bus.pc_i        = ($urandom_range(0, 1) != 0) ? (32'($urandom_range(0, DEPTH - 1)) << 2)
                                                          : 32'($urandom());
            bus.rsp_ready_i = ($urandom_range(0, 2) != 0);
            tick();
            if (obs_fire) begin
                fires++;
                if (exp_q.size() == 0 || obs_rsp !== exp_q[0]) begin
                    errs++;
                    if (errs <= 5)
                        $display("FAIL random_rsp: got instr=%h pc=%h fault=%b, expected instr=%h pc=%h fault=%b",
                                 obs_rsp.instr, obs_rsp.pc, obs_rsp.fault,
                                 (exp_q.size() > 0) ? exp_q[0].instr : 32'h0,
                                 (exp_q.size() > 0) ? exp_q[0].pc : 32'h0,
                                 (exp_q.size() > 0) ? exp_q[0].fault : 1'b0);
                end
                if (exp_q.size() > 0) e = exp_q.pop_front();
            end
        end
        bus.req_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            tick();
            if (obs_fire) begin
                fires++;
                if (obs_rsp !== exp_q[0]) errs++;
                e = exp_q.pop_front();
            end
        end
        n_tests++;
        if (errs != 0 || exp_q.size() != 0 || fires < 100) begin
            n_fail++;
            $display("FAIL random_summary: errors=%0d leftover=%0d responses=%0d, expected 0 0 >=100",
                     errs, exp_q.size(), fires);
        end
    endtask

    task automatic test_reset_mid_burst();
        int stale = 0;
        bus.rsp_ready_i = 1'b0;
        bus.req_valid_i = 1'b1;
        bus.pc_i        = 32'h300;
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({bus.rsp_valid_o, bus.rsp_instr_o, bus.rsp_pc_o, bus.rsp_fault_o, bus.mem_en_o} !== 67'd0) begin
            n_fail++;
            $display("FAIL midrst_async: valid=%b instr=%h pc=%h fault=%b mem_en=%b, expected all zero",
                     bus.rsp_valid_o, bus.rsp_instr_o, bus.rsp_pc_o, bus.rsp_fault_o, bus.mem_en_o);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        exp_q.delete();
        #1;
        n_tests++;
        if (bus.req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_ready: req_ready=%b, expected 1", bus.req_ready_o);
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (obs_valid) stale++;
        end
        n_tests++;
        if (stale != 0) begin
            n_fail++;
            $display("FAIL midrst_stale: stale valid cycles=%0d, expected 0", stale);
        end
    endtask

`ifdef FETCH_FAULT_EN
    task automatic test_address_map();
        bus.rsp_ready_i = 1'b1;
        bus.req_valid_i = 1'b1;
        bus.pc_i        = 32'h0000_0002;
        tick();
        bus.pc_i        = 32'(DEPTH * 4);
        n_tests++;
        if ({obs_accept, obs_mem_en} !== 2'b10) begin
            n_fail++;
            $display("FAIL fault_issue: accept=%b mem_en=%b, expected 1 0", obs_accept, obs_mem_en);
        end
        tick();
        bus.req_valid_i = 1'b0;
        n_tests++;
        if ({obs_valid, obs_rsp} !== {1'b1, 32'h0000_0013, 32'h2, 1'b1} || obs_mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_misaligned: valid=%b instr=%h pc=%h fault=%b mem_en=%b, expected 1 00000013 00000002 1 0",
                     obs_valid, obs_rsp.instr, obs_rsp.pc, obs_rsp.fault, obs_mem_en);
        end
        tick();
        n_tests++;
        if ({obs_valid, obs_rsp} !== {1'b1, 32'h0000_0013, 32'(DEPTH * 4), 1'b1}) begin
            n_fail++;
            $display("FAIL fault_range: valid=%b instr=%h pc=%h fault=%b, expected 1 00000013 %h 1",
                     obs_valid, obs_rsp.instr, obs_rsp.pc, obs_rsp.fault, 32'(DEPTH * 4));
        end
        exp_q.delete();
    endtask
`else
    task automatic test_address_map();
        bus.rsp_ready_i = 1'b1;
        bus.req_valid_i = 1'b1;
        bus.pc_i        = 32'(DEPTH * 4 + 9);
        tick();
        bus.req_valid_i = 1'b0;
        n_tests++;
        if ({obs_accept, obs_mem_en, obs_addr} !== {1'b1, 1'b1, ADDR_W'(2)}) begin
            n_fail++;
            $display("FAIL wrap_issue: accept=%b mem_en=%b addr=%h, expected 1 1 002",
                     obs_accept, obs_mem_en, obs_addr);
        end
        tick();
        n_tests++;
        if ({obs_valid, obs_rsp} !== {1'b1, mem_word(2), 32'(DEPTH * 4 + 9), 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_rsp: valid=%b instr=%h pc=%h fault=%b, expected 1 %h %h 0",
                     obs_valid, obs_rsp.instr, obs_rsp.pc, obs_rsp.fault, mem_word(2), 32'(DEPTH * 4 + 9));
        end
        exp_q.delete();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_address_map();
        test_random();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
